// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings for the SRAM slave.
//   htrans_e     : transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hsize_e      : transfer size (byte/half/word/dword)
//   HRESP_*      : response encodings
//   sram_state_e : data-phase FSM states of the slave
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HS_BYTE  = 3'b000,
        HS_HALF  = 3'b001,
        HS_WORD  = 3'b010,
        HS_DWORD = 3'b011
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } sram_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// ahb_sram_array: DEPTH x DATA_W storage, byte-enable synchronous write,
// asynchronous read. One index serves both ports because the slave only
// ever reads or writes the word captured in the current address phase.
//   i_clk   : clock
//   i_we    : write strobe
//   i_idx   : word index
//   i_be    : byte-lane enables
//   i_wdata : write data
//   o_rdata : word at i_idx (combinational)
module ahb_sram_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_idx,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);
    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents intentionally have no reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (i_be[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite memory slave with configurable width, depth,
// base address and wait states; illegal accesses get a two-cycle ERROR.
//   HCLK/HRESET     : clock, synchronous active-high reset
//   HSEL..HREADY    : address-phase inputs (HWDATA is data phase)
//   HRDATA          : read word during a read data phase, else 0
//   HREADYOUT/HRESP : slave ready and response
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);
    localparam int BYTES = DATA_W / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    // One extra bit so a span equal to the full address space still compares.
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

    sram_state_e        r_state, w_state_nxt;
    logic [3:0]         r_cnt, w_cnt_nxt;
    logic               r_write;
    logic [IDX_W-1:0]   r_idx;
    logic [BYTES-1:0]   r_be;

    logic [ADDR_W-1:0]  w_off, w_mask;
    logic               w_accept, w_legal, w_capture, w_we;
    logic [BYTES-1:0]   w_be;
    logic [DATA_W-1:0]  w_rdata;

    // Unsigned offset: addresses below the base wrap huge and fail the range check.
    assign w_off    = HADDR - BASE_ADDR;
    assign w_mask   = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
    assign w_accept = HSEL && HREADY && (HTRANS == HT_NONSEQ || HTRANS == HT_SEQ);
    assign w_legal  = ({1'b0, w_off} < SPAN) && (HSIZE <= 3'(LB)) && ((HADDR & w_mask) == '0);

    // Lanes [lane, lane + 2^HSIZE) of the addressed word.
    always_comb begin
        int lane;
        w_be = '0;
        lane = int'(w_off[LB-1:0]);
        for (int i = 0; i < BYTES; i++) begin
            w_be[i] = (i >= lane) && (i < lane + (1 << HSIZE));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_write <= HWRITE;
                r_idx   <= w_off[LB +: IDX_W];
                r_be    <= w_be;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        HREADYOUT   = 1'b1;
        HRESP       = HRESP_OKAY;
        case (r_state)
            // Both final data-phase cycles double as an address phase for the next transfer.
            ST_IDLE, ST_LAST, ST_ERR2: begin
                if (r_state == ST_ERR2) HRESP = HRESP_ERROR;
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_capture = 1'b1;
                    if (!w_legal) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt = ST_LAST;
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_cnt == 4'd0) w_state_nxt = ST_LAST;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = HRESP_ERROR;
                w_state_nxt = ST_ERR2;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write lands on the edge that closes the data phase; a reset on that edge drops it.
    assign w_we = (r_state == ST_LAST) && r_write && !HRESET;

    ahb_sram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_idx   (r_idx),
        .i_be    (r_be),
        .i_wdata (HWDATA),
        .o_rdata (w_rdata)
    );

    assign HRDATA = ((r_state == ST_WAIT || r_state == ST_LAST) && !r_write) ? w_rdata : '0;

endmodule
